// File: rtl/psmac_pkg.sv
// Shared definitions for the PSMAC digit-serial multiplier: precision codes,
// sequencer states, digit widths and the precision-to-digit-count helper.
package psmac_pkg;

  localparam logic [1:0] PREC_2 = 2'b00;
  localparam logic [1:0] PREC_4 = 2'b01;
  localparam logic [1:0] PREC_8 = 2'b10;

  localparam int DIGIT_W = 2;
  localparam int DPROD_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } psmac_state_e;

  // Reserved code 2'b11 runs at full 8-bit precision.
  function automatic logic [2:0] digits_for_prec(input logic [1:0] prec);
    case (prec)
      PREC_2:  return 3'd1;
      PREC_4:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/psmac_digit_mul2.sv
// Combinational 2x2 digit multiplier. Each digit is unsigned unless its sign
// flag is set; the 5-bit two's-complement product is exact (range -6..9).
module psmac_digit_mul2
  import psmac_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_da,
  input  logic [DIGIT_W-1:0] i_db,
  input  logic               i_sa,
  input  logic               i_sb,
  output logic [DPROD_W-1:0] o_prod
);

  logic               w_sda;
  logic               w_sdb;
  logic signed [DPROD_W-1:0] w_da;
  logic signed [DPROD_W-1:0] w_db;

  assign w_sda  = i_sa & i_da[DIGIT_W-1];
  assign w_sdb  = i_sb & i_db[DIGIT_W-1];
  assign w_da   = {{(DPROD_W-DIGIT_W){w_sda}}, i_da};
  assign w_db   = {{(DPROD_W-DIGIT_W){w_sdb}}, i_db};
  assign o_prod = w_da * w_db;

endmodule

// File: rtl/psmac_digit_serial_mul.sv
// Digit-serial precision-scalable multiplier: walks 2-bit digit pairs through
// one digit multiplier and shift-adds them. PSMAC_ACC_EN turns it into a MAC.
module psmac_digit_serial_mul
  import psmac_pkg::*;
#(
  parameter int MAX_W     = 8,
  parameter int ACC_GUARD = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [1:0]         i_prec,
  input  logic [MAX_W-1:0]   i_a,
  input  logic [MAX_W-1:0]   i_b,
  input  logic               i_sa,
  input  logic               i_sb,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [2*MAX_W-1:0] o_result
`ifdef PSMAC_ACC_EN
  ,
  input  logic               i_acc_clr
`endif
);

`ifdef PSMAC_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif
  localparam int RES_W = 2 * MAX_W;
  localparam int ACC_W = RES_W + (ACC_EN ? ACC_GUARD : 0);
  localparam int N_MAX = MAX_W / DIGIT_W;
  localparam int IDX_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;

  psmac_state_e       r_state;
  psmac_state_e       w_state_nxt;
  logic [MAX_W-1:0]   r_a;
  logic [MAX_W-1:0]   r_b;
  logic               r_sa;
  logic               r_sb;
  logic [IDX_W-1:0]   r_nlast;
  logic [IDX_W-1:0]   r_i;
  logic [IDX_W-1:0]   r_j;
  logic [ACC_W-1:0]   r_acc;

  logic [2:0]         w_n;
  logic [IDX_W-1:0]   w_nlast_in;
  logic [DIGIT_W-1:0] w_da;
  logic [DIGIT_W-1:0] w_db;
  logic [DPROD_W-1:0] w_pp;
  logic [ACC_W-1:0]   w_pp_ext;
  logic [IDX_W+1:0]   w_sh;
  logic [ACC_W-1:0]   w_term;
  logic               w_last_pair;

  assign w_n        = digits_for_prec(i_prec);
  assign w_nlast_in = IDX_W'(w_n - 3'd1);

  assign w_da = r_a[{r_i, 1'b0} +: DIGIT_W];
  assign w_db = r_b[{r_j, 1'b0} +: DIGIT_W];

  // Only the most significant digit of each operand carries the sign.
  psmac_digit_mul2 u_dmul (
    .i_da   (w_da),
    .i_db   (w_db),
    .i_sa   (r_sa & (r_i == r_nlast)),
    .i_sb   (r_sb & (r_j == r_nlast)),
    .o_prod (w_pp)
  );

  assign w_pp_ext    = {{(ACC_W-DPROD_W){w_pp[DPROD_W-1]}}, w_pp};
  assign w_sh        = {({1'b0, r_i} + {1'b0, r_j}), 1'b0};
  assign w_term      = w_pp_ext << w_sh;
  assign w_last_pair = (r_i == r_nlast) && (r_j == r_nlast);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_state_nxt = BUSY;
      end
      BUSY: if (w_last_pair) w_state_nxt = DONE;
      DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_nlast <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
`ifdef PSMAC_ACC_EN
          if (i_acc_clr) r_acc <= '0;
`endif
          if (i_in_valid) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_sa    <= i_sa;
            r_sb    <= i_sb;
            r_nlast <= w_nlast_in;
            r_i     <= '0;
            r_j     <= '0;
`ifndef PSMAC_ACC_EN
            r_acc   <= '0;
`endif
          end
        end
        BUSY: begin
          r_acc <= r_acc + w_term;
          if (r_j == r_nlast) begin
            r_j <= '0;
            r_i <= r_i + IDX_W'(1);
          end else begin
            r_j <= r_j + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PSMAC_ACC_EN
  always_comb begin
    o_result = '0;
    if (r_state == DONE) o_result = r_acc[RES_W-1:0];
  end
`else
  // Bit 2W-1 of the product sits at index 4*n-1, i.e. {n-1, 2'b11}.
  logic [IDX_W+1:0] w_top_idx;
  logic             w_ext;

  assign w_top_idx = {r_nlast, 2'b11};
  assign w_ext     = (r_sa | r_sb) & r_acc[w_top_idx];

  always_comb begin
    o_result = '0;
    if (r_state == DONE) begin
      for (int k = 0; k < RES_W; k++)
        o_result[k] = (k <= int'(w_top_idx)) ? r_acc[k] : w_ext;
    end
  end
`endif

endmodule

// File: doc/psmac_digit_serial_mul.md
Name: psmac_digit_serial_mul

Overview:
Digit-serial, precision-scalable multiplier sequencer for the PSMAC datapath.
- Splits the two operands into 2-bit digits and feeds each digit pair, with its per-digit sign flags, to a 2x2 digit multiplier.
- Shifts each 5-bit digit product into place and adds it to a wide register, rebuilding the full product.
- Operand precision (2/4/8-bit) and signedness are chosen per operation. Results go out on a valid/ready interface.

Parameters:
- MAX_W, 8, maximum operand width in bits; even; the digit count is MAX_W/2.
- ACC_GUARD, 4, extra accumulator guard bits; used only when PSMAC_ACC_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set.
- prec  in  2  precision: 00 = 2-bit, 01 = 4-bit, 10 = 8-bit, 11 = reserved (treated as 8-bit).
- a  in  MAX_W  multiplicand; only the low W bits are used.
- b  in  MAX_W  multiplier; only the low W bits are used.
- sa  in  1  a is two's complement.
- sb  in  1  b is two's complement.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  2*MAX_W  product; signed if sa|sb, otherwise unsigned; sign-extended from 2W bits.
- acc_clr  in  1  clears the accumulator (port present only with PSMAC_ACC_EN).

Behaviour:
- Reset: state IDLE; in_ready=1, out_valid=0, result=0; digit indices and accumulator are 0.
- State IDLE:
  - in_ready=1.
  - On in_valid: latch prec, a, b, sa, sb; set i=j=0; clear the accumulator; go to BUSY.
  - Handshake cycle is T.
- State BUSY:
  - in_ready=0. n = W/2 digits per operand (n = 1, 2 or 4).
  - Each cycle, take digit pair da = a[2i+1:2i], db = b[2j+1:2j].
  - Per-digit sign flag is sa (resp. sb) only for the top digit (i = n-1, resp. j = n-1); all other digits are unsigned.
  - Digit product:
    - exact 5-bit two's complement;
    - range -6..9 in all sign combinations;
    - sign-extended to the accumulator width;
    - shifted left by 2*(i+j);
    - added to the accumulator.
  - Iteration order: j is the inner loop. Increment j; when j = n-1, wrap j to 0 and increment i.
  - After the pair (n-1, n-1) has been added, go to DONE. BUSY lasts exactly n*n cycles.
- State DONE:
  - out_valid=1 from cycle T+n*n+1.
  - result holds the accumulator, sign-extended from bit 2W-1 when sa|sb, zero-extended otherwise.
  - result and out_valid stay stable until out_ready.
  - On out_valid & out_ready: go to IDLE. in_ready returns the next cycle; no accept happens in the same cycle.
- Latency from accept to out_valid: 2, 5 or 17 cycles for 2-, 4- and 8-bit precision.
- Inputs other than out_ready are ignored in BUSY and DONE. Changes to a, b, prec, sa, sb after the accept have no effect.
- No overflow is possible: 2W bits always hold the exact product for every sign mix.
- Reset asserted mid-operation aborts the operation. The block is back in the reset state the next cycle with no output produced.
- Holding out_ready high in IDLE or BUSY has no effect.

Optional Feature:
Macro PSMAC_ACC_EN.
- Defined:
  - The accumulator is 2*MAX_W+ACC_GUARD bits wide and is NOT cleared on accept. Successive products add into it (MAC).
  - result is the low 2*MAX_W bits of the accumulator.
  - acc_clr=1 in IDLE clears the accumulator. If in_valid arrives in the same cycle, the clear happens first, so the new product starts from 0.
  - acc_clr is ignored outside IDLE.
  - Wrap-around is modulo 2^(2*MAX_W+ACC_GUARD).
- Undefined:
  - The acc_clr port is absent.
  - The accumulator is cleared on every accept.
  - The block behaves as a plain multiplier.

Decomposition:
- Shared package psmac_pkg holds:
  - precision encoding constants PREC_2, PREC_4, PREC_8;
  - FSM state typedef (IDLE, BUSY, DONE);
  - DIGIT_W=2 and DPROD_W=5;
  - function digits_for_prec(prec) returning n.
- One sub-module, psmac_digit_mul2, is natural: a combinational 2x2 digit multiplier with per-digit sign flags and an exact 5-bit signed output. It is instantiated once. The sequencer FSM, index counters and shift-add stay in the top.

Test Plan:
- prec=00, sa=sb=1, a=2'b10, b=2'b10 (-2 x -2) -> out_valid 2 cycles after accept; result=16'h0004.
- prec=01, sa=sb=0, a=4'hF, b=4'hF -> out_valid at accept+5; result=16'd225 (16'h00E1).
- prec=10, sa=1, sb=1, a=8'h80, b=8'h80 -> out_valid at accept+17; result=16'h4000. Same with sa=0, a=8'hFF, sb=1, b=8'hFF -> result=16'hFF01 (-255).
- Backpressure: out_ready=0 for 10 cycles after out_valid -> result and out_valid stable, in_ready=0. Raise out_ready -> in_ready=1 one cycle later. New operands changed during BUSY do not alter the result.
- rst pulse in BUSY cycle 3 of an 8-bit op -> next cycle in_ready=1, out_valid=0, result=0. A following 4-bit op 3 x 5 unsigned gives 16'd15.
- With PSMAC_ACC_EN: acc_clr, then unsigned 4-bit 3x4, then 5x6 -> results 12, then 42. acc_clr plus a new 2x2 unsigned op in the same IDLE cycle -> result 4.
